// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing scheduler: function codes, FSM
// encoding and default datapath dimensions.
package alu_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_FUNC_W   = 4;
  localparam int DEF_MAX_FUNC = 8;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_NOT = 4'd5;
  localparam logic [3:0] FN_SHL = 4'd6;
  localparam logic [3:0] FN_SRA = 4'd7;
  localparam logic [3:0] FN_SRL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the caller owns the last-grant pointer.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // On contention the requester that did not win last time is preferred.
  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant_idx = ~last_grant;
        grant     = last_grant ? 2'b01 : 2'b10;
      end else if (valid0) begin
        grant_idx = 1'b0;
        grant     = 2'b01;
      end else if (valid1) begin
        grant_idx = 1'b1;
        grant     = 2'b10;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: accept, execute
// from registered operands, then hold a tagged response until consumed.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FUNC_W   = DEF_FUNC_W,
  parameter int MAX_FUNC = DEF_MAX_FUNC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_over,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              rsp_over,
  output logic              rsp_err
);

  localparam logic [FUNC_W-1:0] MAX_F  = FUNC_W'(MAX_FUNC);
  localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(FN_ADD);
  localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(FN_SUB);

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [1:0]        grant;
  logic              grant_idx;
  logic              arb_enable;
  logic              accept;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [FUNC_W-1:0] op_func;
  logic              op_id;
  logic              illegal;
  logic              arith;

  // Ready is suppressed while reset is asserted so every output reads 0.
  assign arb_enable = (state == ST_IDLE) && !rst;
  assign accept     = |grant;
  assign illegal    = op_func > MAX_F;
  assign arith      = (op_func == F_ADD) || (op_func == F_SUB);

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    rsp_valid  = (state == ST_RESP);
  end

  // Operand registers feed the ALU in every state; last_grant starts at 1 so req0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_func    <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_a       <= grant_idx ? req1_a    : req0_a;
      op_b       <= grant_idx ? req1_b    : req0_b;
      op_func    <= grant_idx ? req1_func : req0_func;
      op_id      <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_func = op_func;

  // Overflow only has meaning for add/sub; illegal codes report a clean error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out  <= '0;
      rsp_zero <= 1'b0;
      rsp_sign <= 1'b0;
      rsp_over <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_id <= op_id;
      if (illegal) begin
        rsp_out  <= '0;
        rsp_zero <= 1'b0;
        rsp_sign <= 1'b0;
        rsp_over <= 1'b0;
        rsp_err  <= 1'b1;
      end else begin
        rsp_out  <= alu_out;
        rsp_zero <= alu_zero;
        rsp_sign <= alu_sign;
        rsp_over <= alu_over & arith;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule
